// File: rtl/dev_pkg.sv
// Shared widths and entry layouts for the mMIPS device-port stream bridge.
package dev_pkg;

  localparam int unsigned DEV_DATA_W = 32;

  // TX entry is {dest, last, data}; RX entry is {last, data}.
  localparam int unsigned TX_LAST_BIT = DEV_DATA_W;
  localparam int unsigned TX_DEST_LSB = DEV_DATA_W + 1;
  localparam int unsigned RX_LAST_BIT = DEV_DATA_W;
  localparam int unsigned RX_ENTRY_W  = DEV_DATA_W + 1;

  typedef struct packed {
    logic                  last;
    logic [DEV_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic int unsigned tx_entry_w(input int unsigned dest_w);
    return dest_w + DEV_DATA_W + 1;
  endfunction

endpackage

// File: rtl/dev_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module dev_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Push is judged against fullness at the start of the cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dev_stream_bridge.sv
// mMIPS device-port handler: core word strobes to buffered TX/RX streams with EOP and dest.
module dev_stream_bridge
  import dev_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned DEST_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DEV_DATA_W-1:0] dev_dout,
  output logic [DEV_DATA_W-1:0] dev_din,
  input  logic                  dev_r,
  input  logic                  dev_w,
  output logic                  dev_rdyr,
  output logic                  dev_rdyw,
  input  logic                  dev_wdata,
  input  logic                  dev_waddr,
  input  logic                  dev_send_eop,
  output logic                  dev_rcv_eop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEV_DATA_W-1:0] m_data,
  output logic [DEST_W-1:0]     m_dest,
  output logic                  m_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DEV_DATA_W-1:0] s_data,
  input  logic                  s_last,
  output logic                  tx_ovf,
  output logic                  rx_udf
);

  localparam int unsigned TX_W = tx_entry_w(DEST_W);

  logic [DEST_W-1:0]         dest_reg;
  logic                      eop_pending;
  logic                      tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic [TX_W-1:0]           tx_wr, tx_head;
  rx_entry_t                 rx_wr, rx_head;
  logic                      acc_dst, wr_req, acc_wr, wr_drop, acc_rd, rd_udf;
  logic                      unused_counts;

  // Only core-side strobes are gated by en; the stream side keeps flowing.
  assign acc_dst = en & dev_w & dev_waddr;
  assign wr_req  = en & dev_w & dev_wdata & ~dev_waddr;
  assign acc_wr  = wr_req & ~tx_full;
  assign wr_drop = wr_req & tx_full;
  assign acc_rd  = en & dev_r & ~rx_empty;
  assign rd_udf  = en & dev_r & rx_empty;

  assign tx_wr = {dest_reg, dev_send_eop | eop_pending, dev_dout};
  assign rx_wr = '{last: s_last, data: s_data};

  assign m_valid     = ~tx_empty;
  assign m_data      = tx_head[DEV_DATA_W-1:0];
  assign m_last      = tx_head[TX_LAST_BIT];
  assign m_dest      = tx_head[TX_DEST_LSB +: DEST_W];
  assign dev_rdyw    = ~tx_full;
  assign s_ready     = ~rx_full;
  assign dev_rdyr    = ~rx_empty;
  assign dev_din     = rx_head.data;
  assign dev_rcv_eop = rx_head.last;

  assign unused_counts = ^{tx_count, rx_count};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_reg    <= '0;
      eop_pending <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
    end else begin
      if (acc_dst) dest_reg <= dev_dout[DEST_W-1:0];
      // A dropped write leaves a pending EOP untouched.
      if (acc_wr) begin
        eop_pending <= 1'b0;
      end else if (en && dev_send_eop && !wr_drop) begin
        eop_pending <= 1'b1;
      end
      if (wr_drop) tx_ovf <= 1'b1;
      if (rd_udf)  rx_udf <= 1'b1;
    end
  end

  dev_sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_wr),
    .wdata (tx_wr),
    .pop   (m_valid & m_ready),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  dev_sync_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .wdata (rx_wr),
    .pop   (acc_rd),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule
